// File: rtl/ram_arbiter_ctrl.sv
// Two-port round-robin arbiter that expands atomic read/write transactions
// into the single-port RAM's address-then-data command pair.

module ram_arbiter_rsp (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] rdata_in,
  input  logic       err_in,
  output logic       valid,
  output logic [7:0] rdata,
  output logic       err
);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      rdata <= 8'h00;
      err   <= 1'b0;
    end else begin
      valid <= load;
      if (load) begin
        rdata <= rdata_in;
        err   <= err_in;
      end
    end
  end
endmodule

module ram_arbiter_ctrl #(
  parameter int ADDR_SIZE  = 8,
  parameter int RD_TIMEOUT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic                 req0_wr,
  input  logic [ADDR_SIZE-1:0] req0_addr,
  input  logic [7:0]           req0_wdata,
  output logic                 rsp0_valid,
  output logic [7:0]           rsp0_rdata,
  output logic                 rsp0_err,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic                 req1_wr,
  input  logic [ADDR_SIZE-1:0] req1_addr,
  input  logic [7:0]           req1_wdata,
  output logic                 rsp1_valid,
  output logic [7:0]           rsp1_rdata,
  output logic                 rsp1_err,
  output logic [9:0]           ram_din,
  output logic                 ram_rx_valid,
  input  logic [7:0]           ram_dout,
  input  logic                 ram_tx_valid,
  output logic                 busy
);
  localparam int NUM_PORTS = 2;
  localparam int CW = $clog2(RD_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(RD_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(RD_TIMEOUT);

  typedef struct packed {
    logic                 wr;
    logic [ADDR_SIZE-1:0] addr;
    logic [7:0]           wdata;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_WAIT} state_t;

  state_t                          state, state_nxt;
  logic                            last_q, last_nxt;
  logic                            own_q, own_nxt;
  req_t                            txn_q, txn_nxt;
  logic [CW-1:0]                   cnt_q, cnt_nxt;
  logic [NUM_PORTS-1:0]            req_valid, ready;
  req_t [NUM_PORTS-1:0]            req;
  logic                            grant_sel;
  logic [9:0]                      din_c;
  logic                            rx_c;
  logic                            rsp_load;
  logic [7:0]                      rsp_rdata_nxt;
  logic                            rsp_err_nxt;
  logic [NUM_PORTS-1:0]            rsp_valid, rsp_err;
  logic [NUM_PORTS-1:0][7:0]       rsp_rdata;

  assign req_valid = {req1_valid, req0_valid};
  assign req[0]    = {req0_wr, req0_addr, req0_wdata};
  assign req[1]    = {req1_wr, req1_addr, req1_wdata};

  // On a tie the port not granted last wins; otherwise the lone requester.
  assign grant_sel = (req_valid == 2'b11) ? ~last_q : req_valid[1];

  always_comb begin
    state_nxt     = state;
    last_nxt      = last_q;
    own_nxt       = own_q;
    txn_nxt       = txn_q;
    cnt_nxt       = cnt_q;
    ready         = '0;
    din_c         = 10'h000;
    rx_c          = 1'b0;
    rsp_load      = 1'b0;
    rsp_rdata_nxt = 8'h00;
    rsp_err_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (|req_valid) begin
          ready[grant_sel] = 1'b1;
          own_nxt          = grant_sel;
          last_nxt         = grant_sel;
          txn_nxt          = req[grant_sel];
          state_nxt        = S_ADDR;
        end
      end
      S_ADDR: begin
        rx_c      = 1'b1;
        din_c     = {(txn_q.wr ? 2'b00 : 2'b10), txn_q.addr};
        state_nxt = S_DATA;
      end
      S_DATA: begin
        rx_c  = 1'b1;
        din_c = {(txn_q.wr ? 2'b01 : 2'b11), (txn_q.wr ? txn_q.wdata : 8'h00)};
        if (txn_q.wr) begin
          rsp_load  = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt   = '0;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // The ADDR command cleared the RAM's stale tx_valid, so any valid here is ours.
        if (ram_tx_valid) begin
          rsp_load      = 1'b1;
          rsp_rdata_nxt = ram_dout;
          state_nxt     = S_IDLE;
        end else begin
          cnt_nxt = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            rsp_load      = 1'b1;
            rsp_rdata_nxt = 8'hFF;
            rsp_err_nxt   = 1'b1;
            state_nxt     = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      last_q <= 1'b1;
      own_q  <= 1'b0;
      txn_q  <= '0;
      cnt_q  <= '0;
    end else begin
      state  <= state_nxt;
      last_q <= last_nxt;
      own_q  <= own_nxt;
      txn_q  <= txn_nxt;
      cnt_q  <= cnt_nxt;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rsp
    ram_arbiter_rsp u_rsp (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (rsp_load && (own_q == 1'(p))),
      .rdata_in (rsp_rdata_nxt),
      .err_in   (rsp_err_nxt),
      .valid    (rsp_valid[p]),
      .rdata    (rsp_rdata[p]),
      .err      (rsp_err[p])
    );
  end

  // Combinational outputs are forced idle while reset is asserted so a
  // requester never sees an accept that the reset is about to discard.
  assign req0_ready   = rst_n & ready[0];
  assign req1_ready   = rst_n & ready[1];
  assign ram_din      = rst_n ? din_c : 10'h000;
  assign ram_rx_valid = rst_n & rx_c;
  assign busy         = rst_n & (state != S_IDLE);

  assign rsp0_valid = rsp_valid[0];
  assign rsp0_rdata = rsp_rdata[0];
  assign rsp0_err   = rsp_err[0];
  assign rsp1_valid = rsp_valid[1];
  assign rsp1_rdata = rsp_rdata[1];
  assign rsp1_err   = rsp_err[1];
endmodule
